adc_sample_scheduler: RTL

Sequencing controller for the AD4008 serial-readout datapath. Issues periodic conversion-start pulses to the ADC reader and collects the reader's data/flag outputs. Averages 2^k samples into one result and delivers it on a valid/ready stream. Supervises each conversion with a timeout and resets the reader on a hang.

---
 rtl/adc_sample_scheduler.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic ADC conversion scheduler with 2^k averaging; optional ADC_SCHED_TIMESTAMP_EN
module adc_sample_scheduler #(
    parameter int ADC_WIDTH  = 16,
    parameter int MIN_PERIOD = 40,
    parameter int TIMEOUT    = 255,
    parameter int RST_PULSE  = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic [15:0]          period,
    input  logic [2:0]           avg_log2,
    output logic                 conv_start,
    input  logic                 conv_done,
    input  logic [ADC_WIDTH-1:0] conv_data,
    output logic                 drv_resetn,
    output logic [ADC_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 clr_status,
    output logic                 overrun,
    output logic                 missed,
    output logic                 timeout,
    output logic [7:0]           miss_cnt
`ifdef ADC_SCHED_TIMESTAMP_EN
    ,
    output logic [31:0]          m_timestamp
`endif
);

    localparam int AW = ADC_WIDTH + 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RST_PULSE > 1) ? $clog2(RST_PULSE + 1) : 1;
    localparam logic [15:0]   MIN_P   = 16'(MIN_PERIOD);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RST_END = RW'(RST_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_CONVERT,
        S_DELIVER,
        S_RECOVER
    } state_t;

    state_t          state, next_state;
    logic [15:0]     pcnt, p_lat, p_eff;
    logic            tick;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   rcnt;
    logic [AW-1:0]   acc, sum, shifted;
    logic [4:0]      cnt, cnt_inc, n_lat;
    logic [2:0]      sh, sh_in;
    logic            last_sample, tmo_hit, load, can_load, miss_evt;

    assign p_eff       = (period < MIN_P) ? MIN_P : period;
    assign tick        = enable && (state != S_IDLE) && (pcnt == p_lat - 16'd1);
    assign sh_in       = (avg_log2 > 3'd4) ? 3'd4 : avg_log2;
    assign n_lat       = 5'd1 << sh;
    assign cnt_inc     = cnt + 5'd1;
    assign last_sample = (cnt_inc == n_lat);
    assign sum         = acc + AW'(conv_data);
    assign shifted     = sum >> sh;
    assign tmo_hit     = (state == S_CONVERT) && !conv_done && (tcnt == TMO_END);
    // The result register is loaded on the Nth conv_done edge so m_valid follows by one cycle.
    assign load        = (state == S_CONVERT) && conv_done && enable && last_sample;
    assign can_load    = !m_valid || m_ready;
    assign miss_evt    = tick && (state != S_WAIT_TICK);
    assign drv_resetn  = (state != S_RECOVER);

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; dropping enable abandons any partial block
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (enable) next_state = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (!enable)   next_state = S_IDLE;
                else if (tick) next_state = S_CONVERT;
            end
            S_CONVERT: begin
                if (conv_done) begin
                    if (!enable)         next_state = S_IDLE;
                    else if (last_sample) next_state = S_DELIVER;
                    else                 next_state = S_WAIT_TICK;
                end else if (tmo_hit) begin
                    next_state = S_RECOVER;
                end
            end
            S_DELIVER:   next_state = enable ? S_WAIT_TICK : S_IDLE;
            S_RECOVER:   if (rcnt == RST_END) next_state = enable ? S_WAIT_TICK : S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Period counter; a new period value is picked up only at wrap or while idle
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pcnt  <= '0;
            p_lat <= MIN_P;
        end else if (state == S_IDLE || !enable) begin
            pcnt  <= '0;
            p_lat <= p_eff;
        end else if (tick) begin
            pcnt  <= '0;
            p_lat <= p_eff;
        end else begin
            pcnt  <= pcnt + 16'd1;
        end
    end

    // Conversion watchdog and reader-reset pulse length
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            tcnt <= '0;
            rcnt <= '0;
        end else begin
            tcnt <= (state == S_CONVERT) ? tcnt + TW'(1) : '0;
            rcnt <= (state == S_RECOVER) ? rcnt + RW'(1) : '0;
        end
    end

    // Accumulator, sample count and block size latch
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc <= '0;
            cnt <= '0;
            sh  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DELIVER: begin
                    acc <= '0;
                    cnt <= '0;
                    sh  <= sh_in;
                end
                S_CONVERT: if (conv_done) begin
                    acc <= sum;
                    cnt <= cnt_inc;
                end
                S_RECOVER: begin
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // One-cycle start pulse coincides with the first CONVERT cycle
    always_ff @(posedge clk or posedge areset) begin
        if (areset) conv_start <= 1'b0;
        else        conv_start <= (state == S_WAIT_TICK) && tick;
    end

    // Output stream register: hold while stalled, clear on handshake
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load && can_load) begin
            m_data  <= shifted[ADC_WIDTH-1:0];
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Sticky status; clr_status wins over a same-cycle event
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            overrun  <= 1'b0;
            missed   <= 1'b0;
            timeout  <= 1'b0;
            miss_cnt <= '0;
        end else if (clr_status) begin
            overrun  <= 1'b0;
            missed   <= 1'b0;
            timeout  <= 1'b0;
            miss_cnt <= '0;
        end else begin
            if (load && !can_load) overrun <= 1'b1;
            if (tmo_hit)           timeout <= 1'b1;
            if (miss_evt) begin
                missed <= 1'b1;
                if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [31:0] ts_cnt, ts_cap;

    // Free-running cycle stamp captured at the first start of a block, delivered with m_data
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ts_cnt      <= '0;
            ts_cap      <= '0;
            m_timestamp <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if ((state == S_WAIT_TICK) && tick && (cnt == 5'd0)) ts_cap <= ts_cnt + 32'd1;
            if (load && can_load) m_timestamp <= ts_cap;
        end
    end
`endif

endmodule
